// File: rtl/tcb_pkg.sv
// Shared constants and fill-FSM encoding for the TCB 121-64-10
// image input stage.
package tcb_pkg;

   localparam int PIX_W = 8;
   localparam int N_PIX = 121;
   localparam int IMG_W = PIX_W * N_PIX;
   localparam int CNT_W = 7;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PIX - 1);

   typedef enum logic {
      S_FILL = 1'b0,
      S_FULL = 1'b1
   } fill_state_t;

endpackage

// File: rtl/img_stream_packer_if.sv
// Pixel stream in, packed frame out, with their valid/ready
// handshakes and the alignment-error pulse.
interface img_stream_packer_if;

   logic [tcb_pkg::PIX_W-1:0] pix_data;
   logic                      pix_valid;
   logic                      pix_sof;
   logic                      pix_ready;
   logic [tcb_pkg::IMG_W-1:0] img_source;
   logic                      valid_top;
   logic                      ready_top;
   logic                      frame_err;

   modport master (
      output pix_data, pix_valid, pix_sof, ready_top,
      input  pix_ready, img_source, valid_top, frame_err
   );

   modport slave (
      input  pix_data, pix_valid, pix_sof, ready_top,
      output pix_ready, img_source, valid_top, frame_err
   );

endinterface

// File: rtl/img_stream_packer_frame_out_slot.sv
// Output holding register: a frame plus its valid bit, loaded
// from the fill side and released by the downstream transfer.
module frame_out_slot
   import tcb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [IMG_W-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [IMG_W-1:0] o_data
);

   logic             r_valid;
   logic [IMG_W-1:0] r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/img_stream_packer.sv
// Packs a raster stream of 121 8-bit pixels into one 968-bit
// frame; double-buffered behind a single output slot.
module img_stream_packer
   import tcb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   img_stream_packer_if.slave io
);

   fill_state_t      r_state;
   fill_state_t      w_state_nxt;
   logic [IMG_W-1:0] r_fill;
   logic [IMG_W-1:0] w_fill_nxt;
   logic [IMG_W-1:0] w_load_data;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             w_beat;
   logic             w_last;
   logic             w_misalign;
   logic             w_xfer;
   logic             w_slot_free;
   logic             w_load;
   logic             w_valid;
   logic [IMG_W-1:0] w_img;

   assign io.pix_ready = (r_state == S_FILL) & ~rst;

   assign w_beat      = io.pix_valid & io.pix_ready;
   assign w_last      = w_beat & ~io.pix_sof & (r_cnt == LAST_CNT);
   assign w_misalign  = w_beat & io.pix_sof & (r_cnt != '0);
   assign w_xfer      = w_valid & io.ready_top;
   assign w_slot_free = ~w_valid | io.ready_top;
   assign w_fill_nxt  = {r_fill[IMG_W-PIX_W-1:0], io.pix_data};

   // A completed frame bypasses FULL when the slot frees this edge
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_data = w_fill_nxt;
      unique case (r_state)
         S_FILL: begin
            if (w_last) begin
               if (w_slot_free) w_load = 1'b1;
               else             w_state_nxt = S_FULL;
            end
         end
         S_FULL: begin
            w_load_data = r_fill;
            if (w_xfer) begin
               w_load      = 1'b1;
               w_state_nxt = S_FILL;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FILL;
         r_cnt   <= '0;
         r_fill  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_misalign;
         if (w_beat) begin
            r_fill <= w_fill_nxt;
            if (io.pix_sof)  r_cnt <= CNT_W'(1);
            else if (w_last) r_cnt <= '0;
            else             r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   frame_out_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_data  (w_load_data),
      .i_ready (io.ready_top),
      .o_valid (w_valid),
      .o_data  (w_img)
   );

   assign io.valid_top  = w_valid;
   assign io.img_source = w_img;
   assign io.frame_err  = r_err;

endmodule

// File: tb/tb_img_stream_packer.sv
// Directed bench for img_stream_packer: table of frame patterns
// plus backpressure, misaligned-sof and mid-frame-reset sequences.
module tb_img_stream_packer;
   import tcb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   img_stream_packer_if ifc ();

   img_stream_packer dut (
      .clk (clk),
      .rst (rst),
      .io  (ifc.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] base;
      logic [7:0] step;
      bit         gap;
      bit         use_sof;
      logic [7:0] exp_hi;
      logic [7:0] exp_lo;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int vt_cnt = 0;
   int err_cnt = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (ifc.valid_top) vt_cnt++;
      if (ifc.frame_err) err_cnt++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic chk_img(input string nm, input logic [IMG_W-1:0] act,
                          input logic [IMG_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         for (int k = 0; k < N_PIX; k++) begin
            if (act[IMG_W-1-PIX_W*k -: PIX_W] !==
                exp[IMG_W-1-PIX_W*k -: PIX_W]) begin
               $display("FAIL %s: pixel %0d got %0h expected %0h",
                        nm, k, act[IMG_W-1-PIX_W*k -: PIX_W],
                        exp[IMG_W-1-PIX_W*k -: PIX_W]);
               break;
            end
         end
      end
   endtask

   function automatic logic [IMG_W-1:0] pack(input logic [7:0] b,
                                             input logic [7:0] s);
      logic [IMG_W-1:0] v;
      v = '0;
      for (int k = 0; k < N_PIX; k++)
         v[IMG_W-1-PIX_W*k -: PIX_W] = 8'(b + s * k);
      return v;
   endfunction

   task automatic send_pix(input logic [7:0] d, input bit sof,
                           input bit gap);
      bit ok;
      int guard;
      if (gap) begin
         ifc.pix_valid = 1'b0;
         while ($urandom_range(99) >= 40) tick();
      end
      ifc.pix_data  = d;
      ifc.pix_sof   = sof;
      ifc.pix_valid = 1'b1;
      guard = 0;
      ok = 1'b0;
      while (!ok && guard < 500) begin
         ok = ifc.pix_ready;
         tick();
         guard++;
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL beat_timeout: got no pix_ready expected 1");
      end
      ifc.pix_valid = 1'b0;
      ifc.pix_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic [7:0] s,
                             input bit gap, input bit sof);
      for (int k = 0; k < N_PIX; k++)
         send_pix(8'(b + s * k), sof && (k == 0), gap);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      int   t0;
      int   e0;
      int   v0;
      logic [IMG_W-1:0] fa;
      logic [IMG_W-1:0] fb;

      vecs[0] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'h00, 8'h78};
      vecs[1] = '{8'h10, 8'h02, 1'b0, 1'b1, 8'h10, 8'h00};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'h87};
      vecs[3] = '{8'hA5, 8'h00, 1'b0, 1'b0, 8'hA5, 8'hA5};
      vecs[4] = '{8'h03, 8'h03, 1'b1, 1'b0, 8'h03, 8'h6B};

      ifc.pix_data  = 8'h5A;
      ifc.pix_valid = 1'b1;
      ifc.pix_sof   = 1'b1;
      ifc.ready_top = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_valid_top", 32'(ifc.valid_top), 32'd0);
      chk("rst_img_zero", 32'(ifc.img_source == '0), 32'd1);
      chk("rst_pix_ready", 32'(ifc.pix_ready), 32'd0);
      chk("rst_frame_err", 32'(ifc.frame_err), 32'd0);
      rst = 1'b0;
      ifc.pix_valid = 1'b0;
      ifc.pix_sof   = 1'b0;
      tick();
      chk("post_rst_ready", 32'(ifc.pix_ready), 32'd1);
      chk("post_rst_valid", 32'(ifc.valid_top), 32'd0);

      foreach (vecs[i]) begin
         t0 = cyc;
         send_frame(vecs[i].base, vecs[i].step, vecs[i].gap,
                    vecs[i].use_sof);
         chk($sformatf("v%0d_valid", i), 32'(ifc.valid_top), 32'd1);
         if (!vecs[i].gap)
            chk($sformatf("v%0d_latency", i), 32'(cyc - t0), 32'd121);
         chk_img($sformatf("v%0d_img", i), ifc.img_source,
                 pack(vecs[i].base, vecs[i].step));
         chk($sformatf("v%0d_hi", i), 32'(ifc.img_source[967:960]),
             32'(vecs[i].exp_hi));
         chk($sformatf("v%0d_lo", i), 32'(ifc.img_source[7:0]),
             32'(vecs[i].exp_lo));
         tick();
         chk($sformatf("v%0d_drop", i), 32'(ifc.valid_top), 32'd0);
      end

      // Backpressure: two frames queue up behind a stalled consumer
      fa = pack(8'h20, 8'h01);
      fb = pack(8'h40, 8'h03);
      ifc.ready_top = 1'b0;
      send_frame(8'h20, 8'h01, 1'b0, 1'b1);
      chk("bp_a_valid", 32'(ifc.valid_top), 32'd1);
      chk_img("bp_a_img", ifc.img_source, fa);
      send_frame(8'h40, 8'h03, 1'b0, 1'b1);
      chk("bp_full_ready", 32'(ifc.pix_ready), 32'd0);
      chk_img("bp_a_held", ifc.img_source, fa);
      ifc.pix_data  = 8'hEE;
      ifc.pix_valid = 1'b1;
      for (int j = 0; j < 3; j++) tick();
      chk("bp_still_valid", 32'(ifc.valid_top), 32'd1);
      chk("bp_still_full", 32'(ifc.pix_ready), 32'd0);
      chk_img("bp_a_stable", ifc.img_source, fa);
      ifc.pix_valid = 1'b0;
      ifc.ready_top = 1'b1;
      tick();
      chk("bp_b_valid", 32'(ifc.valid_top), 32'd1);
      chk_img("bp_b_img", ifc.img_source, fb);
      chk("bp_refill_ready", 32'(ifc.pix_ready), 32'd1);
      tick();
      chk("bp_b_drop", 32'(ifc.valid_top), 32'd0);
      send_frame(8'h77, 8'h01, 1'b0, 1'b1);
      chk_img("bp_c_img", ifc.img_source, pack(8'h77, 8'h01));
      tick();

      // Misaligned sof at beat 50 restarts the frame
      e0 = err_cnt;
      for (int k = 0; k < 50; k++)
         send_pix(8'(8'hEE + k), k == 0, 1'b0);
      chk("mis_no_err_yet", 32'(err_cnt - e0), 32'd0);
      send_pix(8'h30, 1'b1, 1'b0);
      chk("mis_err_pulse", 32'(ifc.frame_err), 32'd1);
      send_pix(8'h35, 1'b0, 1'b0);
      chk("mis_err_clear", 32'(ifc.frame_err), 32'd0);
      for (int k = 2; k < N_PIX; k++)
         send_pix(8'(8'h30 + 5 * k), 1'b0, 1'b0);
      chk("mis_valid", 32'(ifc.valid_top), 32'd1);
      chk_img("mis_img", ifc.img_source, pack(8'h30, 8'h05));
      chk("mis_err_count", 32'(err_cnt - e0), 32'd1);
      tick();

      // Reset mid-frame: only the following clean frame surfaces
      v0 = vt_cnt;
      for (int k = 0; k < 60; k++)
         send_pix(8'(8'h55 + 7 * k), k == 0, 1'b0);
      rst = 1'b1;
      tick();
      chk("mrst_valid", 32'(ifc.valid_top), 32'd0);
      chk("mrst_img_zero", 32'(ifc.img_source == '0), 32'd1);
      rst = 1'b0;
      send_frame(8'h11, 8'h01, 1'b0, 1'b1);
      chk("mrst_clean_valid", 32'(ifc.valid_top), 32'd1);
      chk_img("mrst_clean_img", ifc.img_source, pack(8'h11, 8'h01));
      tick();
      tick();
      chk("mrst_one_pulse", 32'(vt_cnt - v0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
